// File: rtl/l2_wr_bufs_pkg.sv
// Shared L2 cache types, write-mask bit positions and the queued write entry
// layout used by the L2 write buffers.
package l2_wr_bufs_pkg;

    localparam int L2_WAYS  = 8;
    localparam int L2_SETS  = 16;
    localparam int LINE_W   = 32;
    localparam int TAG_W    = 8;
    localparam int HPROT_W  = 2;
    localparam int STATE_W  = 3;

    typedef logic [$clog2(L2_SETS)-1:0] l2_set_t;
    typedef logic [$clog2(L2_WAYS)-1:0] l2_way_t;
    typedef logic [LINE_W-1:0]          line_t;
    typedef logic [TAG_W-1:0]           l2_tag_t;
    typedef logic [HPROT_W-1:0]         hprot_t;
    typedef logic [STATE_W-1:0]         state_t;

    localparam int L2_WR_MASK_LINE  = 0;
    localparam int L2_WR_MASK_TAG   = 1;
    localparam int L2_WR_MASK_HPROT = 2;
    localparam int L2_WR_MASK_STATE = 3;
    localparam int L2_WR_MASK_EVICT = 4;
    localparam int L2_WR_MASK_W     = 5;

    typedef logic [L2_WR_MASK_W-1:0] l2_wr_mask_t;

    typedef struct packed {
        l2_set_t     set;
        l2_way_t     way;
        l2_wr_mask_t mask;
        line_t       line;
        l2_tag_t     tag;
        hprot_t      hprot;
        state_t      state;
        l2_way_t     evict_way;
    } l2_wr_entry_t;

    function automatic logic set_hit(input l2_set_t a, input l2_set_t b, input logic vld);
        return vld && (a == b);
    endfunction

endpackage

// File: rtl/l2_wr_fifo.sv
// DEPTH-entry circular payload FIFO for L2 write entries; exposes per-slot
// set and occupancy so the parent can compare against in-flight reads.
module l2_wr_fifo
    import l2_wr_bufs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  l2_wr_entry_t               push_data,
    input  logic                       pop,
    output l2_wr_entry_t               head_data,
    output logic [PTR_W:0]             count,
    output l2_set_t [DEPTH-1:0]        ent_set,
    output logic [DEPTH-1:0]           ent_occ
);

    localparam int CNT_W = PTR_W + 1;

    l2_wr_entry_t     mem_q [DEPTH];
    l2_wr_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [PTR_W-1:0] off_s;

    // A full queue refuses pushes even when a pop frees a slot on the same edge.
    assign push_ok_s = push && (count_q != CNT_W'(DEPTH));
    assign pop_ok_s  = pop && (count_q != {CNT_W{1'b0}});

    // Pointer, count and payload next-state.
    always_comb begin
        wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_ok_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (push_ok_s && (wr_ptr_q == PTR_W'(i))) ? push_data : mem_q[i];
        end
    end

    // Slot i is occupied when its distance from the read pointer is below count.
    always_comb begin
        off_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s      = PTR_W'(i) - rd_ptr_q;
            ent_occ[i] = ({1'b0, off_s} < count_q);
            ent_set[i] = mem_q[i].set;
        end
    end

    // Control state with async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are only meaningful while occupied.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/l2_wr_bufs.sv
// L2 write buffers: queues array updates and retires one per idle array cycle.
// Optional read/write set conflict detect is built when L2_WR_SET_CONFLICT_EN is defined.
module l2_wr_bufs
    import l2_wr_bufs_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req_valid,
    output logic        wr_req_ready,
    input  l2_set_t     wr_req_set,
    input  l2_way_t     wr_req_way,
    input  logic [4:0]  wr_req_mask,
    input  line_t       wr_req_line,
    input  l2_tag_t     wr_req_tag,
    input  hprot_t      wr_req_hprot,
    input  state_t      wr_req_state,
    input  l2_way_t     wr_req_evict_way,
    input  logic        rd_mem_en,
    input  l2_set_t     rd_set,
    output logic        wr_en_line,
    output logic        wr_en_tag,
    output logic        wr_en_hprot,
    output logic        wr_en_state,
    output logic        wr_en_evict_way,
    output l2_set_t     wr_set,
    output l2_way_t     wr_way,
    output line_t       wr_data_line,
    output l2_tag_t     wr_data_tag,
    output hprot_t      wr_data_hprot,
    output state_t      wr_data_state,
    output l2_way_t     wr_data_evict_way,
    output logic        wr_idle,
    output logic        wr_set_conflict
);

    localparam int CNT_W = PTR_W + 1;

    l2_wr_entry_t        req_s;
    l2_wr_entry_t        head_s;
    l2_wr_entry_t        out_q, out_d;
    logic [CNT_W-1:0]    count_s;
    l2_set_t [DEPTH-1:0] ent_set_s;
    logic [DEPTH-1:0]    ent_occ_s;
    logic                push_s;
    logic                issue_s;

    // Pack the request fields into a queue entry.
    always_comb begin
        req_s.set       = wr_req_set;
        req_s.way       = wr_req_way;
        req_s.mask      = wr_req_mask;
        req_s.line      = wr_req_line;
        req_s.tag       = wr_req_tag;
        req_s.hprot     = wr_req_hprot;
        req_s.state     = wr_req_state;
        req_s.evict_way = wr_req_evict_way;
    end

    assign wr_req_ready = (count_s != CNT_W'(DEPTH));
    assign push_s       = wr_req_valid && wr_req_ready;
    assign issue_s      = (count_s != {CNT_W{1'b0}}) && !rd_mem_en;

    l2_wr_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (req_s),
        .pop       (issue_s),
        .head_data (head_s),
        .count     (count_s),
        .ent_set   (ent_set_s),
        .ent_occ   (ent_occ_s)
    );

    // Strobes drop on non-issue cycles while the data/address regs hold.
    always_comb begin
        out_d = out_q;
        if (issue_s) begin
            out_d = head_s;
        end else begin
            out_d.mask = {L2_WR_MASK_W{1'b0}};
        end
    end

    // Registered array write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '{default: '0};
        end else begin
            out_q <= out_d;
        end
    end

    assign wr_en_line        = out_q.mask[L2_WR_MASK_LINE];
    assign wr_en_tag         = out_q.mask[L2_WR_MASK_TAG];
    assign wr_en_hprot       = out_q.mask[L2_WR_MASK_HPROT];
    assign wr_en_state       = out_q.mask[L2_WR_MASK_STATE];
    assign wr_en_evict_way   = out_q.mask[L2_WR_MASK_EVICT];
    assign wr_set            = out_q.set;
    assign wr_way            = out_q.way;
    assign wr_data_line      = out_q.line;
    assign wr_data_tag       = out_q.tag;
    assign wr_data_hprot     = out_q.hprot;
    assign wr_data_state     = out_q.state;
    assign wr_data_evict_way = out_q.evict_way;
    assign wr_idle           = (count_s == {CNT_W{1'b0}}) && (out_q.mask == {L2_WR_MASK_W{1'b0}});

`ifdef L2_WR_SET_CONFLICT_EN
    logic hit_s;

    // Match the read set against every occupied slot and the write on the port.
    always_comb begin
        hit_s = set_hit(out_q.set, rd_set, |out_q.mask);
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | set_hit(ent_set_s[i], rd_set, ent_occ_s[i]);
        end
    end

    assign wr_set_conflict = rd_mem_en && hit_s;
`else
    logic conflict_unused_s;

    assign conflict_unused_s = ^{rd_set, ent_set_s, ent_occ_s};
    assign wr_set_conflict   = 1'b0;
`endif

endmodule
